// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// master = controller side, slave = datapath/test side.
interface mc_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       memRead;
    logic       memWrite;
    logic       IorD;
    logic       IRWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALU_controls;
    logic [1:0] PCSrc;
    logic       pcEn;
    logic       err;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output memRead, memWrite, IorD, IRWrite,
        output regDst, memToReg, regWrite, ALUSrcA,
        output ALUSrcB, ALU_controls, PCSrc, pcEn,
        output err, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  memRead, memWrite, IorD, IRWrite,
        input  regDst, memToReg, regWrite, ALUSrcA,
        input  ALUSrcB, ALU_controls, PCSrc, pcEn,
        input  err, state
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM with memory-wait timeout.
// Optional bne support: define MC_CONTROLLER_BNE_EN.
module mc_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic            clk,
    input logic            reset,
    mc_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_ERROR  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROLLER_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t     st;
    state_t     nxt;
    logic [7:0] wait_cnt;
    logic       waiting;
    logic       timed_out;

    assign waiting = (st == S_FETCH) || (st == S_MEMRD) ||
                     (st == S_MEMWR);
    assign timed_out = waiting && !bus.mem_ready &&
                       (wait_cnt == TO_CNT);

    always_comb begin
        nxt = st;
        unique case (st)
            S_FETCH:  if (bus.mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:       nxt = S_BRANCH;
`endif
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
                    default:      nxt = S_FETCH;
                endcase
            end
            S_MEMADR: nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) nxt = S_MEMWB;
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) nxt = S_FETCH;
            S_EXEC:   nxt = S_ALUWB;
            S_ALUWB:  nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_ADDIEX: nxt = S_ADDIWB;
            S_ADDIWB: nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_ERROR:  nxt = S_ERROR;
            default:  nxt = S_FETCH;
        endcase
        // mem_ready in the timeout cycle already advanced above
        if (timed_out) nxt = S_ERROR;
    end

    // Counter restarts on any state change, so every wait state
    // is entered with a fresh count.
    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= S_FETCH;
            wait_cnt <= 8'd0;
        end else begin
            st <= nxt;
            if (nxt != st)
                wait_cnt <= 8'd0;
            else if (waiting && !bus.mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic [1:0] pc_src;
    logic       pc_en;

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctl    = 3'b000;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        unique case (st)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctl   = ALU_ADD;
                ir_write  = bus.mem_ready;
                pc_en     = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctl   = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctl   = funct_alu(bus.funct);
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctl   = ALU_SUB;
                pc_src    = 2'b01;
`ifdef MC_CONTROLLER_BNE_EN
                pc_en = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
                pc_en = bus.zero;
`endif
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // reset blocks every architectural write in the same cycle
        if (reset) begin
            mem_write = 1'b0;
            reg_write = 1'b0;
            ir_write  = 1'b0;
            pc_en     = 1'b0;
        end
    end

    assign bus.memRead      = mem_read;
    assign bus.memWrite     = mem_write;
    assign bus.IorD         = iord;
    assign bus.IRWrite      = ir_write;
    assign bus.regDst       = reg_dst;
    assign bus.memToReg     = mem_to_reg;
    assign bus.regWrite     = reg_write;
    assign bus.ALUSrcA      = alu_src_a;
    assign bus.ALUSrcB      = alu_src_b;
    assign bus.ALU_controls = alu_ctl;
    assign bus.PCSrc        = pc_src;
    assign bus.pcEn         = pc_en;
    assign bus.err          = (st == S_ERROR);
    assign bus.state        = st;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: instruction-level reference
// model pushes per-cycle expectations, a negedge monitor checks them.
module tb_mc_controller;

    localparam int TO = 3;

    localparam int FETCH  = 0;
    localparam int DECODE = 1;
    localparam int MEMADR = 2;
    localparam int MEMRD  = 3;
    localparam int MEMWB  = 4;
    localparam int MEMWR  = 5;
    localparam int EXEC   = 6;
    localparam int ALUWB  = 7;
    localparam int BRANCH = 8;
    localparam int ADDIEX = 9;
    localparam int ADDIWB = 10;
    localparam int JUMP   = 11;
    localparam int ERROR  = 12;

`ifdef MC_CONTROLLER_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] st;
        logic       mrd;
        logic       mwr;
        logic       iord;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic [1:0] pcs;
        logic       pce;
        logic       err;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_controller_if bus();

    mc_controller #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    obs_t expq[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic obs_t outs(input int st, input bit mr,
                                  input bit z, input bit bne,
                                  input logic [2:0] alu,
                                  input bit rst);
        obs_t e;
        e = '0;
        e.st = 4'(st);
        case (st)
            FETCH: begin
                e.mrd = 1; e.srcb = 2'b01; e.alu = 3'b010;
                e.irw = mr; e.pce = mr;
            end
            DECODE: begin e.srcb = 2'b11; e.alu = 3'b010; end
            MEMADR, ADDIEX: begin
                e.srca = 1; e.srcb = 2'b10; e.alu = 3'b010;
            end
            MEMRD: begin e.mrd = 1; e.iord = 1; end
            MEMWB: begin e.m2r = 1; e.rw = 1; end
            MEMWR: begin e.mwr = 1; e.iord = 1; end
            EXEC: begin e.srca = 1; e.alu = alu; end
            ALUWB: begin e.rdst = 1; e.rw = 1; end
            BRANCH: begin
                e.srca = 1; e.alu = 3'b110; e.pcs = 2'b01;
                e.pce = bne ? ~z : z;
            end
            ADDIWB: e.rw = 1;
            JUMP: begin e.pcs = 2'b10; e.pce = 1; end
            ERROR: e.err = 1;
            default: ;
        endcase
        if (rst) begin
            e.rw = 0; e.mwr = 0; e.irw = 0; e.pce = 0;
        end
        return e;
    endfunction

    task automatic step(input bit rst, input logic [5:0] op,
                        input logic [5:0] fn, input bit z,
                        input bit mr, input obs_t e, input bit chk);
        reset = rst;
        bus.opcode = op;
        bus.funct = fn;
        bus.zero = z;
        bus.mem_ready = mr;
        if (chk) expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a.st = bus.state;
            a.mrd = bus.memRead;
            a.mwr = bus.memWrite;
            a.iord = bus.IorD;
            a.irw = bus.IRWrite;
            a.rdst = bus.regDst;
            a.m2r = bus.memToReg;
            a.rw = bus.regWrite;
            a.srca = bus.ALUSrcA;
            a.srcb = bus.ALUSrcB;
            a.alu = bus.ALU_controls;
            a.pcs = bus.PCSrc;
            a.pce = bus.pcEn;
            a.err = bus.err;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL ctl t=%0t got st=%0d bits=%h exp st=%0d bits=%h",
                         $time, a.st, a[19:0], e.st, e[19:0]);
            end
        end
    end

    // Stay in a memory-wait state: w cycles of mem_ready=0, then 1.
    // res: 0 advanced, 1 timed out to ERROR, 2 reset applied.
    task automatic phase_wait(input int st, input int w, input int rst_at,
                              input logic [5:0] op, input logic [5:0] fn,
                              input bit z, input bit bne,
                              input logic [2:0] alu, output int res);
        bit mr;
        res = 0;
        for (int k = 0; k <= 255; k++) begin
            if (k == rst_at) begin
                step(1, op, fn, z, 1, outs(st, 1, z, bne, alu, 1), 1);
                res = 2;
                return;
            end
            mr = (k >= w);
            step(0, op, fn, z, mr, outs(st, mr, z, bne, alu, 0), 1);
            if (mr) return;
            if (k == TO) begin
                res = 1;
                return;
            end
        end
    endtask

    task automatic err_recover();
        int n;
        bit z;
        bit mr;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            z = 1'($urandom);
            mr = 1'($urandom);
            step(0, 6'($urandom), 6'($urandom), z, mr,
                 outs(ERROR, mr, z, 0, 0, 0), 1);
        end
        step(1, 6'd0, 6'd0, 0, 1, outs(ERROR, 1, 0, 0, 0, 1), 1);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input bit z,
                             input int rst_at);
        int res;
        int seq[$];
        bit bne;
        bit mr;
        logic [2:0] alu;
        bne = BNE_EN && (op == 6'b000101);
        alu = alu_of(fn);
        phase_wait(FETCH, wf, -1, op, fn, z, bne, alu, res);
        if (res == 1) begin
            err_recover();
            return;
        end
        mr = 1'($urandom);
        step(0, op, fn, z, mr, outs(DECODE, mr, z, bne, alu, 0), 1);
        case (op)
            6'b100011: seq = '{MEMADR, MEMRD};
            6'b101011: seq = '{MEMADR, MEMWR};
            6'b000000: seq = '{EXEC, ALUWB};
            6'b000100: seq = '{BRANCH};
            6'b000101: if (BNE_EN) seq = '{BRANCH};
            6'b001000: seq = '{ADDIEX, ADDIWB};
            6'b000010: seq = '{JUMP};
            default: ;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == MEMRD || seq[i] == MEMWR) begin
                phase_wait(seq[i], wm, rst_at, op, fn, z, bne, alu, res);
                if (res == 1) begin
                    err_recover();
                    return;
                end
                if (res == 2) return;
                if (seq[i] == MEMRD) begin
                    mr = 1'($urandom);
                    step(0, op, fn, z, mr, outs(MEMWB, mr, z, 0, alu, 0), 1);
                end
            end else begin
                mr = 1'($urandom);
                step(0, op, fn, z, mr, outs(seq[i], mr, z, bne, alu, 0), 1);
            end
        end
    endtask

    function automatic int rand_wait();
        if ($urandom_range(0, 9) == 0) return $urandom_range(4, 5);
        return $urandom_range(0, 3);
    endfunction

    initial begin
        logic [5:0] ops[9];
        logic [5:0] fns[6];
        logic [5:0] op;
        logic [5:0] fn;
        int wm;
        int ra;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                6'b001000, 6'b000010, 6'b111111, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b101010, 6'b000000};
        bus.opcode = '0;
        bus.funct = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        step(1, 6'd0, 6'd0, 0, 1, '0, 0);
        step(1, 6'd0, 6'd0, 0, 1, outs(FETCH, 1, 0, 0, 0, 1), 1);

        run_instr(6'b000000, 6'b100010, 0, 0, 0, -1);
        run_instr(6'b100011, 6'b000000, 0, 3, 0, -1);
        run_instr(6'b000100, 6'b000000, 1, 0, 1, -1);
        run_instr(6'b000100, 6'b000000, 0, 0, 0, -1);
        run_instr(6'b000000, 6'b000000, 4, 0, 0, -1);
        run_instr(6'b000101, 6'b000000, 0, 0, 0, -1);
        run_instr(6'b000101, 6'b000000, 0, 0, 1, -1);
        run_instr(6'b111111, 6'b000000, 0, 0, 0, -1);
        run_instr(6'b101011, 6'b000000, 0, 2, 0, 0);
        run_instr(6'b101011, 6'b000000, 2, 3, 1, -1);
        run_instr(6'b100011, 6'b000000, 0, 4, 0, -1);
        run_instr(6'b001000, 6'b000000, 0, 0, 0, -1);
        run_instr(6'b000010, 6'b000000, 0, 0, 1, -1);

        for (int n = 0; n < 400; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                               : ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                               : fns[$urandom_range(0, 5)];
            wm = rand_wait();
            ra = ($urandom_range(0, 15) == 0) ? $urandom_range(0, wm) : -1;
            run_instr(op, fn, rand_wait(), wm, 1'($urandom), ra);
        end

        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter: TIMEOUT, 15, max memory-wait cycles before error (legal range 1..255).
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high.
REQ-004 Port: opcode  in  6  instr[31:26], sampled from the instruction register.
REQ-005 Port: funct  in  6  instr[5:0].
REQ-006 Port: zero  in  1  ALU zero flag.
REQ-007 Port: mem_ready  in  1  memory access completes this cycle.
REQ-008 Port: memRead, memWrite, IorD, IRWrite  out  1 each  memory and instruction-register control.
REQ-009 Port: regDst, memToReg, regWrite, ALUSrcA  out  1 each  register-file and ALU operand control.
REQ-010 Port: ALUSrcB  out  2  00 reg, 01 const 4, 10 signext, 11 signext<<2.
REQ-011 Port: ALU_controls  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 Port: PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-013 Port: pcEn  out  1  PC load enable.
REQ-014 Port: err  out  1  sticky timeout flag.
REQ-015 Port: state  out  4  current FSM state, for debug.

Function
REQ-016 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ERROR.
REQ-017 FETCH: memRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_controls=010, PCSrc=00; IRWrite=pcEn=mem_ready; advance to DECODE only when mem_ready=1, otherwise stay.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, add; next by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, any other opcode -> FETCH (treated as nop).
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, add; lw -> MEMRD, sw -> MEMWR.
REQ-020 MEMRD: memRead=1, IorD=1; mem_ready -> MEMWB, else stay.
REQ-021 MEMWB: regDst=0, memToReg=1, regWrite=1; -> FETCH.
REQ-022 MEMWR: memWrite=1, IorD=1; mem_ready -> FETCH, else stay; memWrite stays high for every wait cycle.
REQ-023 EXEC: ALUSrcA=1, ALUSrcB=00; funct 100000/100010/100100/100101/101010 -> 010/110/000/001/111; unknown funct -> 010; -> ALUWB.
REQ-024 ALUWB: regDst=1, memToReg=0, regWrite=1; -> FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, pcEn=zero; -> FETCH.
REQ-026 ADDIEX: ALUSrcA=1, ALUSrcB=10, add; -> ADDIWB. ADDIWB: regDst=0, memToReg=0, regWrite=1; -> FETCH.
REQ-027 JUMP: PCSrc=10, pcEn=1; -> FETCH.
REQ-028 Wait counter: 8 bits; cleared on entering FETCH, MEMRD or MEMWR; increments each cycle spent in one of these states with mem_ready=0.
REQ-029 Timeout: if the counter equals TIMEOUT while mem_ready=0, next state is ERROR; mem_ready=1 in that same cycle wins and the FSM advances normally.
REQ-030 ERROR: err=1 and all write enables 0; only reset leaves ERROR.
REQ-031 All outputs not listed for a state are 0; at most one of memWrite, regWrite and IRWrite is high in any cycle.

Reset
REQ-032 reset=1 at a clock edge -> state=FETCH, counter=0, err=0, from any state including mid-wait.
REQ-033 While reset=1, regWrite, memWrite, IRWrite and pcEn are forced to 0, regardless of mem_ready.

Configuration
REQ-034 Macro MC_CONTROLLER_BNE_EN defined: opcode 000101 in DECODE -> BRANCH, and pcEn=~zero in BRANCH for bne.
REQ-035 Macro undefined: opcode 000101 is treated as unknown -> FETCH; no bne logic is present.

Verification
REQ-036 Check: reset, then mem_ready=1 with opcode 000000 and funct 100010 -> states FETCH, DECODE, EXEC (ALU_controls=110), ALUWB (regWrite=1, regDst=1), FETCH.
REQ-037 Check: lw (100011), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with memToReg=1 and regWrite=1.
REQ-038 Check: beq (000100) with zero=1 -> pcEn=1, PCSrc=01 in BRANCH; repeat with zero=0 -> pcEn=0.
REQ-039 Check: TIMEOUT=3 and mem_ready held 0 in FETCH -> ERROR entered after 4 cycles in FETCH, err=1 sticky; reset -> FETCH, err=0.
REQ-040 Check: opcode 000101 -> BRANCH with pcEn=~zero when MC_CONTROLLER_BNE_EN is defined, DECODE -> FETCH when it is not; opcode 111111 -> DECODE -> FETCH.
REQ-041 Check: reset asserted in MEMWR with mem_ready=1 -> memWrite=0 that cycle, FETCH next.
